// File: rtl/display_scan_mux.sv
// Seven-segment driver for N hex digits: continuous multiplexed scan or pulse-stepped sequential presentation.
// Latency: state/idx update on the clock edge that samples load/step; AN/SEG/DP follow one cycle later.
// Backpressure: none; load/step are single-cycle pulses, enable=0 blanks the display and freezes divider/stepping.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   load    latch value/dp_in and (re)start the mode selected by 'mode'
//   value   hex nibbles, digit i = value[4i+3:4i]
//   dp_in   decimal point request per digit (1 = lit)
//   mode    0 = continuous scan, 1 = sequential step (sampled on load)
//   step    advance one digit in sequential mode
//   enable  0 forces the display dark, counters hold
//   SEG     segments {g,f,e,d,c,b,a}, active-low
//   DP      decimal point, active-low
//   AN      anodes, active-low, at most one low
//   busy    high while a sequential presentation runs
//   done    one-cycle pulse when a sequential presentation ends

module display_scan_mux #(
    parameter int N_DIGITS    = 8,
    parameter int SCAN_DIV    = 100000,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    mode,
    input  logic                    step,
    input  logic                    enable,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [N_DIGITS-1:0]     AN,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = $clog2(SCAN_DIV);

    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEQ  = 2'd2
    } state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [DW-1:0]           divider;
    logic [4*N_DIGITS-1:0]   val_reg;
    logic [N_DIGITS-1:0]     dp_reg;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM. load wins over everything else, including a step or a
    // divider wrap in the same cycle; it is honoured even with enable=0.
    // busy is high exactly while the FSM sits in SEQ.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            divider <= '0;
            val_reg <= '0;
            dp_reg  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                val_reg <= value;
                dp_reg  <= dp_in;
                idx     <= '0;
                divider <= '0;
                if (mode) begin
                    state <= SEQ;
                    busy  <= 1'b1;
                end else begin
                    state <= SCAN;
                    busy  <= 1'b0;
                end
            end else if (enable) begin
                case (state)
                    SCAN: begin
                        if (divider == DIV_LAST) begin
                            divider <= '0;
                            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        end else begin
                            divider <= divider + 1'b1;
                        end
                    end
                    SEQ: begin
                        if (step) begin
                            if (idx == IDX_LAST) begin
                                state <= IDLE;
                                idx   <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit decode from the current idx/state; registered below so every
    // pin is glitch-free and lags the control state by one cycle.
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0] an_d;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [N_DIGITS-1:0] lead_zero;   // lead_zero[i]: nibbles i..N-1 are all zero
    logic                zacc;
    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                lz_sel;
    logic                blank;

    always_comb begin
        an_d      = '1;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        lead_zero = '0;
        zacc      = 1'b1;
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        lz_sel    = 1'b0;
        blank     = 1'b0;

        // Walk from the most significant digit down, accumulating "all zero so far".
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zacc         = zacc & (val_reg[4*i +: 4] == 4'h0);
            lead_zero[i] = zacc;
        end

        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib_sel = val_reg[4*i +: 4];
                dp_sel  = dp_reg[i];
                lz_sel  = lead_zero[i];
            end
        end

        // Digit 0 is never blanked so a zero value still shows a single '0'.
        // A blanked digit keeps its anode low so scan timing is unchanged.
        blank = (BLANK_ZEROS != 0) && (idx != '0) && lz_sel;

        if (enable && (state != IDLE)) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                an_d[i] = (idx != IW'(i));
            end
            seg_d = blank ? 7'h7F : hex7(nib_sel);
            dp_d  = ~dp_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN  <= '1;
            SEG <= 7'h7F;
            DP  <= 1'b1;
        end else begin
            AN  <= an_d;
            SEG <= seg_d;
            DP  <= dp_d;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux with N_DIGITS=4, SCAN_DIV=4.
// Each driven cycle pushes the expected pin state to a queue; it is popped and compared after the edge.
// Directed checks against hand-derived constants accompany the scoreboard.

module tb_display_scan_mux;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        mode;
    logic        step;
    logic        enable;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 idle, 1 scan, 2 sequential.
    int          m_state;
    int          m_idx;
    int          m_div;
    logic [15:0] m_val;
    logic [3:0]  m_dp;

    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    display_scan_mux #(
        .N_DIGITS   (N),
        .SCAN_DIV   (DIV),
        .BLANK_ZEROS(1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .value  (value),
        .dp_in  (dp_in),
        .mode   (mode),
        .step   (step),
        .enable (enable),
        .SEG    (SEG),
        .DP     (DP),
        .AN     (AN),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_idx   = 0;
        m_div   = 0;
        m_val   = '0;
        m_dp    = '0;
    endtask

    // One clock cycle: predict, push, clock, pop, compare. Called just after a negedge.
    task automatic tick();
        exp_t        e;
        exp_t        q;
        logic [15:0] sh;
        e.an   = 4'hF;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.done = 1'b0;
        // Pins registered at this edge show the pre-edge model state.
        if (reset && enable && m_state != 0) begin
            e.an  = ~(4'b0001 << m_idx);
            sh    = m_val >> (4 * m_idx);
            e.seg = (m_idx != 0 && sh == 16'h0) ? 7'h7F : seg_of(sh[3:0]);
            e.dp  = ~m_dp[m_idx];
        end
        if (!reset) begin
            model_reset();
        end else if (load) begin
            m_val   = value;
            m_dp    = dp_in;
            m_idx   = 0;
            m_div   = 0;
            m_state = mode ? 2 : 1;
        end else if (enable) begin
            if (m_state == 1) begin
                m_div++;
                if (m_div == DIV) begin
                    m_div = 0;
                    m_idx = (m_idx + 1) % N;
                end
            end else if (m_state == 2 && step) begin
                if (m_idx == N - 1) begin
                    m_state = 0;
                    m_idx   = 0;
                    e.done  = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
        e.busy = (m_state == 2);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        q = sb.pop_front();
        check("sb_an",   32'(AN),   32'(q.an));
        check("sb_seg",  32'(SEG),  32'(q.seg));
        check("sb_dp",   32'(DP),   32'(q.dp));
        check("sb_busy", 32'(busy), 32'(q.busy));
        check("sb_done", 32'(done), 32'(q.done));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        load   = 1'b0;
        value  = '0;
        dp_in  = '0;
        mode   = 1'b0;
        step   = 1'b0;
        enable = 1'b1;
        model_reset();

        // Reset state
        tick();
        tick();
        check("rst_an",   32'(AN),   32'hF);
        check("rst_seg",  32'(SEG),  32'h7F);
        check("rst_dp",   32'(DP),   32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_no_load_an", 32'(AN), 32'hF);

        // Scan 12AF: F, A, 2, 1 then wrap
        value = 16'h12AF; mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        check("load_out_lag_an", 32'(AN), 32'hF);
        for (int k = 0; k < 5; k++) begin
            logic [6:0] s_exp;
            logic [15:0] v;
            v = 16'h12AF >> (4 * (k % 4));
            s_exp = seg_of(v[3:0]);
            tick();
            check("scan_an",  32'(AN),  32'(an_tab[k % 4]));
            check("scan_seg", 32'(SEG), 32'(s_exp));
            repeat (3) tick();
        end

        // Asynchronous reset mid-scan
        tick();
        #2 reset = 1'b0;
        #1;
        check("arst_an",   32'(AN),   32'hF);
        check("arst_seg",  32'(SEG),  32'h7F);
        check("arst_busy", 32'(busy), 32'h0);
        model_reset();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("post_arst_an", 32'(AN), 32'hF);

        // Leading-zero blanking: 0005
        value = 16'h0005; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("blank_an",  32'(AN),  32'(an_tab[k]));
            check("blank_seg", 32'(SEG), (k == 0) ? 32'h12 : 32'h7F);
            repeat (3) tick();
        end

        // Sequential 00C3
        value = 16'h00C3; mode = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        check("seq_busy", 32'(busy), 32'h1);
        tick();
        check("seq_d0_an",  32'(AN),  32'hE);
        check("seq_d0_seg", 32'(SEG), 32'h30);
        step = 1'b1; tick(); step = 1'b0;
        tick();
        check("seq_d1_an",  32'(AN),  32'hD);
        check("seq_d1_seg", 32'(SEG), 32'h46);
        step = 1'b1; tick(); step = 1'b0;
        tick();
        check("seq_d2_an",  32'(AN),  32'hB);
        check("seq_d2_seg", 32'(SEG), 32'h7F);
        step = 1'b1; tick(); step = 1'b0;
        tick();
        check("seq_d3_an",  32'(AN),  32'h7);
        check("seq_d3_seg", 32'(SEG), 32'h7F);
        step = 1'b1; tick(); step = 1'b0;
        check("seq_done",     32'(done), 32'h1);
        check("seq_end_busy", 32'(busy), 32'h0);
        tick();
        check("seq_done_pulse", 32'(done), 32'h0);
        check("seq_end_an",     32'(AN),   32'hF);

        // load beats step; enable=0 freezes stepping
        load = 1'b1; tick(); load = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        load = 1'b1; step = 1'b1; tick();
        load = 1'b0; step = 1'b0;
        tick();
        check("load_wins_an", 32'(AN), 32'hE);
        enable = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        check("disabled_an", 32'(AN), 32'hF);
        check("disabled_seg", 32'(SEG), 32'h7F);
        tick();
        enable = 1'b1;
        tick();
        check("frozen_idx_an", 32'(AN), 32'hE);

        // Decimal point on digit 2 only; 0400 also tests zero under a nonzero digit
        value = 16'h0400; dp_in = 4'b0100; mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dp_an",  32'(AN), 32'(an_tab[k]));
            check("dp_dp",  32'(DP), (k == 2) ? 32'h0 : 32'h1);
            check("dp_seg", 32'(SEG), (k == 2) ? 32'h19 : (k == 3) ? 32'h7F : 32'h40);
            repeat (3) tick();
        end

        // Random mix against the scoreboard
        for (int r = 0; r < 400; r++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h00FF;
                2: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            load   = ($urandom_range(0, 24) == 0);
            mode   = 1'($urandom);
            value  = 16'($urandom) & mask;
            dp_in  = 4'($urandom);
            step   = ($urandom_range(0, 2) == 0);
            enable = ($urandom_range(0, 7) != 0);
            tick();
        end
        load = 1'b0; step = 1'b0; enable = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
